// File: rtl/ex_div.sv
// ex_div: multi-cycle 32-bit restoring divider for the EX stage.
// Computes one quotient bit per cycle and supports signed and unsigned divides.
// Ports:
//   clk           - clock, rising edge
//   rst           - asynchronous active-high reset
//   signed_div_i  - 1 = signed divide, 0 = unsigned divide
//   opdata1_i     - dividend
//   opdata2_i     - divisor
//   start_i       - divide request, held high until the result is consumed
//   annul_i       - discard the operation in progress
//   result_o      - {remainder, quotient}; the upper half goes to HI, the lower half to LO
//   ready_o       - result_o is valid
module ex_div (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    typedef enum logic [1:0] {
        S_FREE,
        S_BYZERO,
        S_ON,
        S_END
    } state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic [31:0] dvd;
    logic [31:0] dvs;
    logic [31:0] rem;
    logic        neg_q;
    logic        neg_r;

    logic [31:0] op1_abs;
    logic [31:0] op2_abs;
    logic [32:0] pr_sh;
    logic        q_bit;
    logic [31:0] rem_nxt;
    logic [31:0] q_fin;
    logic [31:0] q_out;
    logic [31:0] r_out;

    // Two's-complement magnitude; 0x80000000 maps to itself, which
    // is still the right unsigned magnitude.
    assign op1_abs = (signed_div_i && opdata1_i[31]) ?
                     (~opdata1_i + 32'd1) : opdata1_i;
    assign op2_abs = (signed_div_i && opdata2_i[31]) ?
                     (~opdata2_i + 32'd1) : opdata2_i;

    // One restoring step. The dividend register shifts left each cycle,
    // freeing its LSB for the new quotient bit, so after 32 steps it
    // holds the quotient.
    always_comb begin
        pr_sh   = {rem, dvd[31]};
        q_bit   = (pr_sh >= {1'b0, dvs});
        rem_nxt = q_bit ? (pr_sh[31:0] - dvs) : pr_sh[31:0];
        q_fin   = {dvd[30:0], q_bit};
        q_out   = neg_q ? (~q_fin + 32'd1) : q_fin;
        r_out   = neg_r ? (~rem_nxt + 32'd1) : rem_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_FREE;
            cnt      <= 5'd0;
            dvd      <= 32'd0;
            dvs      <= 32'd0;
            rem      <= 32'd0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result_o <= 64'd0;
            ready_o  <= 1'b0;
        end else begin
            unique case (state)
                S_FREE: begin
                    ready_o  <= 1'b0;
                    result_o <= 64'd0;
                    if (start_i && !annul_i) begin
                        if (opdata2_i == 32'd0) begin
                            state <= S_BYZERO;
                        end else begin
                            state <= S_ON;
                            cnt   <= 5'd0;
                            dvd   <= op1_abs;
                            dvs   <= op2_abs;
                            rem   <= 32'd0;
                            neg_q <= signed_div_i &
                                     (opdata1_i[31] ^ opdata2_i[31]);
                            neg_r <= signed_div_i & opdata1_i[31];
                        end
                    end
                end
                S_BYZERO: begin
                    result_o <= 64'd0;
                    if (annul_i) begin
                        state   <= S_FREE;
                        ready_o <= 1'b0;
                    end else begin
                        state   <= S_END;
                        ready_o <= 1'b1;
                    end
                end
                S_ON: begin
                    if (annul_i) begin
                        state    <= S_FREE;
                        ready_o  <= 1'b0;
                        result_o <= 64'd0;
                    end else begin
                        dvd <= q_fin;
                        rem <= rem_nxt;
                        cnt <= cnt + 5'd1;
                        if (cnt == 5'd31) begin
                            state    <= S_END;
                            ready_o  <= 1'b1;
                            result_o <= {r_out, q_out};
                        end
                    end
                end
                S_END: begin
                    if (annul_i || !start_i) begin
                        state    <= S_FREE;
                        ready_o  <= 1'b0;
                        result_o <= 64'd0;
                    end
                end
                default: begin
                    state    <= S_FREE;
                    ready_o  <= 1'b0;
                    result_o <= 64'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_div.sv
// tb_ex_div: directed self-checking bench for ex_div.
// Covers latency, signed/unsigned results, divide-by-zero, annul and reset.
module tb_ex_div;

    logic        clk;
    logic        rst;
    logic        signed_div;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;

    int n_chk;
    int n_pass;

    ex_div dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (opdata1),
        .opdata2_i    (opdata2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a divide, scramble operands during the operation, check the
    // latency and result, hold start for 'hold' cycles, then release.
    task automatic divide(input string tag, input logic [31:0] a,
                          input logic [31:0] b, input logic sg,
                          input int lat, input logic [63:0] exp,
                          input int hold);
        int n;
        opdata1 = a;
        opdata2 = b;
        signed_div = sg;
        start = 1'b1;
        tick();
        opdata1 = ~a;
        opdata2 = 32'h5;
        signed_div = ~sg;
        n = 0;
        while (!ready && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_lat"}, 64'(n), 64'(lat));
        check({tag, "_res"}, result, exp);
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, "_hold_rdy"}, 64'(ready), 64'd1);
            check({tag, "_hold_res"}, result, exp);
        end
        start = 1'b0;
        tick();
        check({tag, "_rel_rdy"}, 64'(ready), 64'd0);
        check({tag, "_rel_res"}, result, 64'd0);
    endtask

    initial begin
        int n;
        logic seen;
        n_chk = 0;
        n_pass = 0;
        rst = 1'b1;
        start = 1'b0;
        annul = 1'b0;
        signed_div = 1'b0;
        opdata1 = 32'd0;
        opdata2 = 32'd0;
        #22;
        check("rst_rdy", 64'(ready), 64'd0);
        check("rst_res", result, 64'd0);
        rst = 1'b0;
        tick();

        divide("u100_7", 32'd100, 32'd7, 1'b0, 32,
               {32'h2, 32'hE}, 0);
        divide("s_m7_2", 32'hFFFFFFF9, 32'h2, 1'b1, 32,
               {32'hFFFFFFFF, 32'hFFFFFFFD}, 0);
        divide("u_m7_2", 32'hFFFFFFF9, 32'h2, 1'b0, 32,
               {32'h1, 32'h7FFFFFFC}, 0);
        divide("s_7_m2", 32'h7, 32'hFFFFFFFE, 1'b1, 32,
               {32'h1, 32'hFFFFFFFD}, 0);
        divide("s_m9_m2", 32'hFFFFFFF7, 32'hFFFFFFFE, 1'b1, 32,
               {32'hFFFFFFFF, 32'h4}, 0);
        divide("u_max_1", 32'hFFFFFFFF, 32'h1, 1'b0, 32,
               {32'h0, 32'hFFFFFFFF}, 0);
        divide("byzero", 32'h12345678, 32'h0, 1'b0, 1,
               64'd0, 0);
        divide("hold", 32'h7FFFFFFF, 32'h10, 1'b0, 32,
               {32'hF, 32'h07FFFFFF}, 5);

        // Annul at ON step 10; no result may ever appear.
        opdata1 = 32'd1000;
        opdata2 = 32'd3;
        signed_div = 1'b0;
        start = 1'b1;
        tick();
        repeat (10) @(posedge clk);
        #1;
        annul = 1'b1;
        start = 1'b0;
        tick();
        annul = 1'b0;
        check("annul_rdy", 64'(ready), 64'd0);
        seen = 1'b0;
        repeat (40) begin
            tick();
            if (ready) seen = 1'b1;
        end
        check("annul_never_rdy", 64'(seen), 64'd0);
        check("annul_res", result, 64'd0);
        divide("after_annul", 32'd9, 32'd3, 1'b0, 32,
               {32'h0, 32'h3}, 0);

        // start dropped mid-operation must not abort it.
        opdata1 = 32'd1000;
        opdata2 = 32'd7;
        signed_div = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!ready && n < 40) begin
            tick();
            n++;
        end
        check("nostart_lat", 64'(n), 64'd32);
        check("nostart_res", result, {32'h6, 32'h8E});
        tick();
        check("nostart_free", 64'(ready), 64'd0);

        // Asynchronous reset while a result is being presented.
        opdata1 = 32'd100;
        opdata2 = 32'd7;
        start = 1'b1;
        tick();
        repeat (32) @(posedge clk);
        #1;
        check("end_rdy", 64'(ready), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_end_rdy", 64'(ready), 64'd0);
        check("arst_end_res", result, 64'd0);
        start = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        // Reset at ON step 20, then the overflow case.
        opdata1 = 32'hFFFFFFFF;
        opdata2 = 32'd3;
        start = 1'b1;
        tick();
        repeat (20) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_on_rdy", 64'(ready), 64'd0);
        check("arst_on_res", result, 64'd0);
        start = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        divide("s_ovf", 32'h80000000, 32'hFFFFFFFF, 1'b1, 32,
               {32'h0, 32'h80000000}, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ex_div.md
EX_DIV -- requirements
Module: ex_div

Interface
- Parameters: none. Operand width is fixed at 32 bits; the result is fixed at 64 bits.
- REQ-001 clk  input  1  Single clock; all state changes on its rising edge.
- REQ-002 rst  input  1  Asynchronous, active-high reset.
- REQ-003 signed_div_i  input  1  1 selects a signed divide, 0 an unsigned divide; sampled with start_i.
- REQ-004 opdata1_i  input  32  Dividend; sampled on the accepting edge.
- REQ-005 opdata2_i  input  32  Divisor; sampled on the accepting edge.
- REQ-006 start_i  input  1  Divide request from the EX stage; held high until the EX stage consumes the result.
- REQ-007 annul_i  input  1  Abort request (pipeline flush or exception); discards the operation in progress.
- REQ-008 result_o  output  64  {remainder[31:0], quotient[31:0]}; the upper half goes to HI and the lower half to LO.
- REQ-009 ready_o  output  1  High while result_o is valid.

Function
- REQ-010 The block SHALL implement four states: FREE, BYZERO, ON and END.
- REQ-011 In FREE, with start_i=1 and annul_i=0:
  - divisor == 0 -> next state BYZERO;
  - otherwise -> next state ON, step counter = 0, operands latched.
- REQ-012 In FREE, with start_i=0 or annul_i=1, the block SHALL stay in FREE with ready_o=0 and result_o=0.
- REQ-013 Signed mode SHALL latch the two's-complement absolute values of both operands; unsigned mode latches the operands unchanged.
- REQ-014 Each ON cycle SHALL perform one restoring step:
  - shift the next dividend bit (MSB first) into the 33-bit partial remainder;
  - if the partial remainder >= divisor, subtract the divisor and shift in quotient bit 1;
  - otherwise shift in quotient bit 0.
- REQ-015 ON SHALL last exactly 32 cycles. On the step with counter == 31, the next state SHALL be END and result_o SHALL be loaded.
- REQ-016 Signed result correction:
  - quotient negated when the operand signs differ;
  - remainder negated when the dividend is negative.
- REQ-017 Arithmetic SHALL wrap modulo 2^32. 0x80000000 / 0xFFFFFFFF signed SHALL yield quotient 0x80000000 and remainder 0.
- REQ-018 BYZERO SHALL go to END on the next edge, with result_o = 0.
- REQ-019 In END, ready_o SHALL be 1 and result_o SHALL hold stable while start_i=1.
- REQ-020 In END, start_i=0 SHALL return the block to FREE on the next edge, with ready_o=0 and result_o=0.
- REQ-021 Latency, counted from the accepting edge E0:
  - normal divide: ready_o rises after edge E32 (the 32nd edge after E0);
  - divide-by-zero: ready_o rises after edge E1.
- REQ-022 annul_i=1 in ON or BYZERO SHALL force FREE on the next edge, with ready_o=0. Partial results SHALL be discarded and never presented.
- REQ-023 annul_i=1 in END SHALL force FREE on the next edge.
- REQ-024 In ON, changes on opdata1_i, opdata2_i and signed_div_i SHALL have no effect.
- REQ-025 In ON, a deassertion of start_i without annul_i SHALL NOT abort the operation; the block completes to END.
- REQ-026 A new operation SHALL be accepted only from FREE; back-to-back divides therefore need at least one FREE cycle between them.
- REQ-027 ready_o and result_o SHALL be registered outputs with no combinational path from any input.

Reset
- REQ-028 While rst=1, regardless of clk:
  - state = FREE, step counter = 0;
  - ready_o = 0, result_o = 0;
  - all internal operand and partial registers = 0.
- REQ-029 Assertion of rst in any state, including mid-ON, SHALL abort the operation immediately.
- REQ-030 The first start_i sampled after rst deasserts SHALL be accepted normally.

Verification
- REQ-031 Unsigned divide: 100 / 7 -> ready_o rises after E32; result_o = {0x00000002, 0x0000000E}.
- REQ-032 Signed divide: 0xFFFFFFF9 / 0x00000002 (i.e. -7 / 2) -> result_o = {0xFFFFFFFF, 0xFFFFFFFD}.
- REQ-033 Divide by zero: 0x12345678 / 0 -> ready_o high after E1; result_o = 0.
- REQ-034 Annul: annul_i pulsed at ON step 10 -> FREE; ready_o never asserts. A following 9 / 3 request -> result_o = {0, 3}.
- REQ-035 Hold and handshake: start_i held 5 cycles in END -> result_o stable, ready_o=1. start_i dropped -> ready_o=0 and result_o=0 next cycle.
- REQ-036 Reset mid-operation: rst asserted asynchronously at ON step 20 -> ready_o=0 and result_o=0 immediately. After release, 0x80000000 / 0xFFFFFFFF signed -> {0, 0x80000000}.
